f_pc_gen: RTL and testbench

F_PC_GEN -- requirements
Module: f_pc_gen

---
 rtl/f_pc_gen_if.sv | 27 ++
 rtl/f_pc_gen.sv | 101 ++++++++++
 tb/tb_f_pc_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_pc_gen_if.sv
// Fetch-PC generator bus: D-stage redirect controls in, fetch address and status out.
interface f_pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             imem_ready;
  logic             req;
  logic [2:0]       npc_op;
  logic [WIDTH-1:0] D_PC;
  logic [25:0]      imm26;
  logic [WIDTH-1:0] ra_data;
  logic             cmp_out;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] F_PC;
  logic             F_adel;
  logic             pend_valid;

  modport master (
    output stall, imem_ready, req, npc_op, D_PC, imm26, ra_data, cmp_out, epc,
    input  F_PC, F_adel, pend_valid
  );

  modport slave (
    input  stall, imem_ready, req, npc_op, D_PC, imm26, ra_data, cmp_out, epc,
    output F_PC, F_adel, pend_valid
  );
endinterface

// File: rtl/f_pc_gen.sv
// Fetch PC generator: sequential/redirect next-PC selection with a one-entry
// redirect buffer that holds a target while instruction memory is not ready.
module f_pc_gen #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [WIDTH-1:0] PC_LO    = 32'h0000_3000,
  parameter logic [WIDTH-1:0] PC_HI    = 32'h0000_6ffc,
  parameter logic [WIDTH-1:0] ERET_OFS = 32'd4
) (
  input logic        clk,
  input logic        reset,
  f_pc_gen_if.slave  bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             pend_q, pend_d;
  logic             adel_q;
  logic [WIDTH-1:0] tgt, jal_tgt, br_ofs;
  logic signed [17:0] br_sh;
  logic             live, adv;

  function automatic logic adel_of(input logic [WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (a < PC_LO) || (a > PC_HI);
  endfunction

  // Narrow builds have no upper PC bits to keep across a jal.
  if (WIDTH > 28) begin : g_jal_wide
    assign jal_tgt = {bus.D_PC[WIDTH-1:28], bus.imm26, 2'b00};
  end else begin : g_jal_narrow
    assign jal_tgt = WIDTH'({bus.imm26, 2'b00});
  end

  assign br_sh  = {bus.imm26[15:0], 2'b00};
  assign br_ofs = WIDTH'(br_sh);
  assign adv    = bus.imem_ready && !bus.stall;

  always_comb begin
    tgt  = '0;
    live = 1'b0;
    case (bus.npc_op)
      3'b001: begin tgt = jal_tgt;                          live = 1'b1;        end
      3'b010: begin tgt = bus.ra_data;                      live = 1'b1;        end
      3'b011: begin tgt = bus.D_PC + WIDTH'(4) + br_ofs;    live = bus.cmp_out; end
      3'b100: begin tgt = bus.epc + ERET_OFS;               live = 1'b1;        end
      default: ;
    endcase
    live = live && !bus.stall;
  end

  // Priority: req > buffered redirect > live D redirect > sequential > hold.
  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (bus.req) begin
      if (bus.imem_ready) begin
        pc_d   = EXC_VEC;
        pend_d = 1'b0;
      end else begin
        pend_pc_d = EXC_VEC;
        pend_d    = 1'b1;
      end
    end else if (pend_q) begin
      // Any live D redirect is dropped here; the older buffered one wins.
      if (adv) begin
        pc_d   = pend_pc_q;
        pend_d = 1'b0;
      end
    end else if (live) begin
      if (bus.imem_ready) begin
        pc_d = tgt;
      end else begin
        pend_pc_d = tgt;
        pend_d    = 1'b1;
      end
    end else if (adv) begin
      pc_d = pc_q + WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      adel_q    <= adel_of(RESET_PC);
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      adel_q    <= adel_of(pc_d);
    end
  end

  assign bus.F_PC       = pc_q;
  assign bus.F_adel     = adel_q;
  assign bus.pend_valid = pend_q;

endmodule

// File: tb/tb_f_pc_gen.sv
// Scoreboard bench for f_pc_gen: each step pushes the expected post-edge state,
// which is popped and compared one cycle later.
module tb_f_pc_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  f_pc_gen_if #(.WIDTH(32)) bus ();

  f_pc_gen #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        rdy;
    logic        req;
    logic [2:0]  op;
    logic [31:0] dpc;
    logic [25:0] imm;
    logic [31:0] ra;
    logic        cmp;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } step_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic apply(input step_t s);
    exp_t e;
    reset          = s.rst;
    bus.stall      = s.stall;
    bus.imem_ready = s.rdy;
    bus.req        = s.req;
    bus.npc_op     = s.op;
    bus.D_PC       = s.dpc;
    bus.imm26      = s.imm;
    bus.ra_data    = s.ra;
    bus.cmp_out    = s.cmp;
    bus.epc        = s.epc;
    e.pc   = s.pc;
    e.pend = s.pend;
    e.adel = s.adel;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t st[1];
    exp_t  e;
    st[0] = '{rst:1'b1, req:1'b1, stall:1'b1, pc:32'h3000, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL reset[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL reset[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL reset[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_sequential();
    step_t st[3];
    exp_t  e;
    st[0] = '{rdy:1'b1, pc:32'h3004, default:'0};
    st[1] = '{rdy:1'b1, pc:32'h3008, default:'0};
    st[2] = '{rdy:1'b1, pc:32'h300c, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL seq[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL seq[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL seq[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_branch();
    step_t st[4];
    exp_t  e;
    st[0] = '{rdy:1'b1, op:3'd3, dpc:32'h3004, imm:26'hfffe, cmp:1'b1, pc:32'h3000, default:'0};
    st[1] = '{rdy:1'b1, op:3'd3, dpc:32'h3004, imm:26'hfffe, cmp:1'b0, pc:32'h3004, default:'0};
    st[2] = '{rdy:1'b1, stall:1'b1, op:3'd3, dpc:32'h3004, imm:26'h0040, cmp:1'b1,
              pc:32'h3004, default:'0};
    st[3] = '{rdy:1'b0, pc:32'h3004, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL branch[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL branch[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL branch[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_jal_buffered();
    step_t st[5];
    exp_t  e;
    st[0] = '{rdy:1'b0, op:3'd1, dpc:32'h3004, imm:26'h0000c10, pc:32'h3004, pend:1'b1,
              default:'0};
    st[1] = '{rdy:1'b0, op:3'd1, dpc:32'h3004, imm:26'h0000c10, pc:32'h3004, pend:1'b1,
              default:'0};
    // A newer jr while buffered must not displace the jal target.
    st[2] = '{rdy:1'b0, op:3'd2, ra:32'h3100, pc:32'h3004, pend:1'b1, default:'0};
    st[3] = '{rdy:1'b1, op:3'd2, ra:32'h3100, pc:32'h3040, default:'0};
    st[4] = '{rdy:1'b1, pc:32'h3044, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL jal_buf[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL jal_buf[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL jal_buf[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_req();
    step_t st[7];
    exp_t  e;
    st[0] = '{req:1'b1, stall:1'b1, rdy:1'b1, pc:32'h4180, default:'0};
    st[1] = '{rdy:1'b1, pc:32'h4184, default:'0};
    st[2] = '{rdy:1'b0, op:3'd1, imm:26'h0000c10, pc:32'h4184, pend:1'b1, default:'0};
    st[3] = '{req:1'b1, rdy:1'b0, pc:32'h4184, pend:1'b1, default:'0};
    st[4] = '{stall:1'b1, rdy:1'b1, pc:32'h4184, pend:1'b1, default:'0};
    st[5] = '{rdy:1'b1, pc:32'h4180, default:'0};
    st[6] = '{rdy:1'b1, pc:32'h4184, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL req[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL req[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL req[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_jr_eret();
    step_t st[5];
    exp_t  e;
    st[0] = '{rdy:1'b1, op:3'd2, ra:32'h3002, pc:32'h3002, adel:1'b1, default:'0};
    st[1] = '{rdy:1'b1, op:3'd2, ra:32'h7000, pc:32'h7000, adel:1'b1, default:'0};
    st[2] = '{rdy:1'b1, op:3'd4, epc:32'h3010, pc:32'h3014, default:'0};
    st[3] = '{rdy:1'b1, stall:1'b1, op:3'd2, ra:32'h5000, pc:32'h3014, default:'0};
    st[4] = '{rdy:1'b1, op:3'd5, ra:32'h5000, pc:32'h3018, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL jr_eret[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL jr_eret[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL jr_eret[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_bounds();
    step_t st[6];
    exp_t  e;
    st[0] = '{rdy:1'b1, op:3'd2, ra:32'h6ffc, pc:32'h6ffc, default:'0};
    st[1] = '{rdy:1'b1, pc:32'h7000, adel:1'b1, default:'0};
    st[2] = '{rdy:1'b1, op:3'd2, ra:32'h2ffc, pc:32'h2ffc, adel:1'b1, default:'0};
    st[3] = '{rdy:1'b1, op:3'd2, ra:32'hffff_fffc, pc:32'hffff_fffc, adel:1'b1, default:'0};
    st[4] = '{rdy:1'b1, pc:32'h0000_0000, adel:1'b1, default:'0};
    st[5] = '{rdy:1'b1, op:3'd2, ra:32'h3000, pc:32'h3000, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL bounds[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL bounds[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL bounds[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  task automatic test_reset_mid_buffer();
    step_t st[4];
    exp_t  e;
    st[0] = '{rdy:1'b1, pc:32'h3004, default:'0};
    st[1] = '{rdy:1'b0, op:3'd1, imm:26'h0000c10, pc:32'h3004, pend:1'b1, default:'0};
    st[2] = '{rst:1'b1, req:1'b1, rdy:1'b1, op:3'd1, imm:26'h0000c10, pc:32'h3000,
              default:'0};
    st[3] = '{rdy:1'b1, pc:32'h3004, default:'0};
    foreach (st[i]) begin
      apply(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk += 3;
      if (bus.F_PC !== e.pc) begin
        n_fail++; $display("FAIL rst_mid[%0d] F_PC got %h want %h", i, bus.F_PC, e.pc);
      end
      if (bus.pend_valid !== e.pend) begin
        n_fail++; $display("FAIL rst_mid[%0d] pend got %b want %b", i, bus.pend_valid, e.pend);
      end
      if (bus.F_adel !== e.adel) begin
        n_fail++; $display("FAIL rst_mid[%0d] adel got %b want %b", i, bus.F_adel, e.adel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jal_buffered();
    test_req();
    test_jr_eret();
    test_bounds();
    test_reset_mid_buffer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
